// File: rtl/ap_ctrl_pkg.sv
// Shared types and default widths for the ap_ctrl_chain stimulus driver.
package ap_ctrl_pkg;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned CYC_W = 32;
    localparam int unsigned DLY_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

    typedef logic [CNT_W-1:0] count_t;
    typedef logic [CYC_W-1:0] cyc_t;

endpackage

// File: rtl/ap_continue_throttle.sv
// Holds each ap_done un-acknowledged for a programmed number of cycles before raising
// ap_continue, and counts the acknowledged dones.
module ap_continue_throttle
    import ap_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = ap_ctrl_pkg::CNT_W,
    parameter int unsigned DLY_W = ap_ctrl_pkg::DLY_W
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             i_clear,
    input  logic [DLY_W-1:0] i_clear_delay,
    input  logic [DLY_W-1:0] i_reload_delay,
    input  logic             i_busy,
    input  logic             i_done,
    input  logic [CNT_W-1:0] i_started_cnt,
    output logic             o_continue,
    output logic             o_ack,
    output logic             o_illegal_done,
    output logic [CNT_W-1:0] o_done_cnt
);

    logic [DLY_W-1:0] r_dcnt;
    logic [CNT_W-1:0] r_done_cnt;
    logic             w_done_legal;

    // A done with no outstanding start is flagged and otherwise ignored.
    assign w_done_legal   = i_busy && i_done && (r_done_cnt != i_started_cnt);
    assign o_illegal_done = i_busy && i_done && (r_done_cnt == i_started_cnt);
    assign o_continue     = i_busy && (r_dcnt == '0);
    assign o_ack          = w_done_legal && (r_dcnt == '0);
    assign o_done_cnt     = r_done_cnt;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_dcnt     <= '0;
            r_done_cnt <= '0;
        end else if (i_clear) begin
            r_dcnt     <= i_clear_delay;
            r_done_cnt <= '0;
        end else if (o_ack) begin
            r_dcnt     <= i_reload_delay;
            r_done_cnt <= r_done_cnt + CNT_W'(1);
        end else if (w_done_legal) begin
            r_dcnt     <= r_dcnt - DLY_W'(1);
        end
    end

endmodule

// File: rtl/ap_ctrl_chain_driver.sv
// Stimulus-side ap_ctrl_chain master: issues a programmed number of ap_start handshakes,
// throttles ap_continue, and raises finish once every done has been acknowledged.
module ap_ctrl_chain_driver
    import ap_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = ap_ctrl_pkg::CNT_W,
    parameter int unsigned CYC_W = ap_ctrl_pkg::CYC_W,
    parameter int unsigned DLY_W = ap_ctrl_pkg::DLY_W
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             enable,
    input  logic [CNT_W-1:0] num_trans,
    input  logic [DLY_W-1:0] cont_delay,
    output logic             dut_ap_start,
    input  logic             dut_ap_ready,
    input  logic             dut_ap_done,
    output logic             dut_ap_continue,
    output logic [CNT_W-1:0] started_cnt,
    output logic [CNT_W-1:0] done_cnt,
    output logic [CYC_W-1:0] run_cycles,
    output logic             busy,
    output logic             finish,
    output logic             protocol_err
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_num;
    logic [DLY_W-1:0] r_delay;
    logic [CNT_W-1:0] r_started;
    logic [CYC_W-1:0] r_cycles;
    logic             r_start;
    logic             r_err;

    logic             w_busy;
    logic             w_run_start;
    logic             w_hs;
    logic             w_last_start;
    logic             w_ack;
    logic             w_illegal_done;
    logic             w_all_done;
    logic [CNT_W-1:0] w_done_cnt;

    assign w_busy       = (r_state == ISSUE) || (r_state == DRAIN);
    assign w_run_start  = (r_state == IDLE) && enable;
    assign w_hs         = r_start && dut_ap_ready && (r_state == ISSUE);
    assign w_last_start = w_hs && (r_started == r_num - CNT_W'(1));
    // True when done_cnt equals N after this cycle's acknowledge is applied.
    assign w_all_done   = (w_done_cnt == r_num) ||
                          (w_ack && (w_done_cnt == r_num - CNT_W'(1)));

    ap_continue_throttle #(
        .CNT_W(CNT_W),
        .DLY_W(DLY_W)
    ) u_throttle (
        .ap_clk        (ap_clk),
        .ap_rst_n      (ap_rst_n),
        .i_clear       (w_run_start),
        .i_clear_delay (cont_delay),
        .i_reload_delay(r_delay),
        .i_busy        (w_busy),
        .i_done        (dut_ap_done),
        .i_started_cnt (r_started),
        .o_continue    (dut_ap_continue),
        .o_ack         (w_ack),
        .o_illegal_done(w_illegal_done),
        .o_done_cnt    (w_done_cnt)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (enable) begin
                    w_state_nxt = (num_trans == '0) ? FINISH : ISSUE;
                end
            end
            ISSUE: begin
                if (w_last_start) begin
                    w_state_nxt = w_all_done ? FINISH : DRAIN;
                end
            end
            DRAIN: begin
                if (w_all_done) begin
                    w_state_nxt = FINISH;
                end
            end
            FINISH: begin
                if (!enable) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state   <= IDLE;
            r_num     <= '0;
            r_delay   <= '0;
            r_started <= '0;
            r_cycles  <= '0;
            r_start   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_run_start) begin
                r_num     <= num_trans;
                r_delay   <= cont_delay;
                r_started <= '0;
                r_cycles  <= '0;
                r_start   <= (num_trans != '0);
            end else begin
                if (w_hs) begin
                    r_started <= r_started + CNT_W'(1);
                end
                if (w_last_start) begin
                    r_start <= 1'b0;
                end
                if (w_busy && (r_cycles != '1)) begin
                    r_cycles <= r_cycles + CYC_W'(1);
                end
            end
            if (w_illegal_done || ((r_state == IDLE) && (dut_ap_done || dut_ap_ready))) begin
                r_err <= 1'b1;
            end
        end
    end

    assign dut_ap_start = r_start;
    assign started_cnt  = r_started;
    assign done_cnt     = w_done_cnt;
    assign run_cycles   = r_cycles;
    assign busy         = w_busy;
    assign finish       = (r_state == FINISH);
    assign protocol_err = r_err;

endmodule

// File: doc/ap_ctrl_chain_driver.md
Name: ap_ctrl_chain_driver

Overview:
- Synthesizable stimulus-side master for the HLS ap_ctrl_chain block-level handshake.
- Drives ap_start and ap_continue into a DUT (e.g. fir), issues a programmed number of transactions, and throttles done acknowledgement by a programmable delay.
- Raises the finish level that the dataflow monitors sample to end the run.
- Sits in the sim/verilog bench beside the DUT, opposite the handshake observers.

Parameters:
- CNT_W, 16, width of transaction count inputs and counters.
- CYC_W, 32, width of the run cycle counter.
- DLY_W, 8, width of the continue-delay input.

Ports:
- ap_clk  in  1  clock, all logic rising-edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- enable  in  1  level; high in IDLE starts a run; low in FINISH returns to IDLE.
- num_trans  in  CNT_W  transactions to issue; latched on run start.
- cont_delay  in  DLY_W  cycles ap_done is held un-acknowledged before ap_continue; latched on run start.
- dut_ap_start  out  1  to DUT ap_start.
- dut_ap_ready  in  1  from DUT.
- dut_ap_done  in  1  from DUT.
- dut_ap_continue  out  1  to DUT ap_continue.
- started_cnt  out  CNT_W  accepted starts (ap_start&&ap_ready).
- done_cnt  out  CNT_W  acknowledged dones (ap_done&&ap_continue).
- run_cycles  out  CYC_W  cycles spent in ISSUE+DRAIN.
- busy  out  1  high in ISSUE or DRAIN.
- finish  out  1  high in FINISH.
- protocol_err  out  1  sticky error flag.

Behaviour:
- Reset: asynchronous, active-low (ap_rst_n); one clock (ap_clk). On reset all outputs, counters and latched inputs go to 0 and the state goes to IDLE. dut_ap_start drops immediately, including mid-run.
- States: IDLE, ISSUE, DRAIN, FINISH.
- IDLE: on enable=1, latch num_trans/cont_delay, clear counters and run_cycles, and load dcnt<=cont_delay. Go to FINISH if num_trans==0, else to ISSUE.
- ISSUE:
  - dut_ap_start=1 as a registered output, asserted from the cycle after entry.
  - Never withdrawn before a handshake.
  - Each cycle with ap_start&&ap_ready increments started_cnt.
  - When that handshake makes started_cnt==N, ap_start falls the next cycle and the state goes to DRAIN.
  - If the final done is acknowledged in that same cycle, go straight to FINISH.
- DRAIN: ap_start=0. Go to FINISH when done_cnt==N.
- FINISH: finish=1, busy=0; counters hold. When enable=0, return to IDLE.
- Continue throttle, active only while busy:
  - dut_ap_continue = busy && (dcnt==0), combinational from registers.
  - On ap_done&&ap_continue: done_cnt++ and dcnt reloads cont_delay.
  - Otherwise, when ap_done and dcnt!=0, dcnt decrements.
  - Net effect: a done first seen at cycle t is acknowledged at t+cont_delay.
  - cont_delay=0 means ap_continue is high throughout busy.
- run_cycles increments every busy cycle and saturates at all-ones.
- protocol_err (sticky until reset):
  - ap_done seen with done_cnt==started_cnt while busy (done without start).
  - ap_done or ap_ready seen in IDLE.
  - In either case the illegal done is not counted.
- Simultaneous start handshake and done acknowledge in one cycle: both counters update.
- num_trans at max (2^CNT_W−1): counters do not wrap.

Decomposition:
- Shared package ap_ctrl_pkg holds:
  - state enum typedef (IDLE/ISSUE/DRAIN/FINISH);
  - default widths CNT_W/CYC_W/DLY_W;
  - count_t/cyc_t typedefs.
- One sub-module: ap_continue_throttle, which owns dcnt, dut_ap_continue, the ack pulse and done_cnt.

Test Plan:
- N=3, cont_delay=0, DUT ready every cycle, done 5 cycles after start → started_cnt=3, done_cnt=3, ap_continue constantly high while busy, finish rises one cycle after the 3rd done ack, run_cycles=8.
- N=2, cont_delay=4, DUT holds ap_done until continue → each done acknowledged exactly 4 cycles after ap_done rises; done_cnt increments at those cycles only.
- N=4, ap_ready low for 3 cycles before each accept → ap_start stays high through every stall, started_cnt=4, no extra starts.
- N=0 with enable=1 → FINISH next cycle, ap_start never asserted, counters 0; enable=0 → IDLE.
- ap_rst_n low mid-ISSUE after 2 starts → ap_start=0 asynchronously, all counters 0, state IDLE; with enable still high after release, a new run starts cleanly.
- ap_done pulse with started_cnt=0 during ISSUE → protocol_err=1 sticky, done_cnt stays 0.
